// File: rtl/gc_poll_scheduler.sv
// rtl/gc_poll_scheduler.sv - GameCube link life-cycle and poll supervision FSM
// Probe -> origin -> steady polling, with timeouts, miss counting and backoff.
module gc_poll_scheduler #(
  parameter int TIMEOUT_CYC = 60000,
  parameter int GAP_CYC     = 600,
  parameter int MAX_MISS    = 3,
  parameter int BACKOFF_CYC = 600000,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_req,
  input  logic       rumble_req,
  input  logic       rx_done,
  input  logic       rx_ok,
  input  logic       rx_origin_bit,
  output logic       gen_hold,
  output logic       gen_go,
  output logic [2:0] cmd_type,
  output logic       rumble,
  output logic       link_up,
  output logic       rpt_valid,
  output logic [1:0] miss_cnt
);

  typedef enum logic [2:0] {
    S_BACKOFF, S_PROBE_WAIT, S_ORIG_WAIT, S_POLL_IDLE, S_POLL_WAIT, S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] BO_LAST  = CNT_W'(BACKOFF_CYC - 1);

  state_t           r_state, r_gap_tgt;
  logic [CNT_W-1:0] r_timer;
  logic [2:0]       r_cmd;
  logic             r_rumble, r_link, r_rpt, r_pending;
  logic [1:0]       r_miss;

  state_t     w_state_nxt, w_gap_tgt_nxt;
  logic       w_timer_clr, w_link_nxt, w_rpt_nxt, w_launch_poll;
  logic [1:0] w_miss_nxt, w_miss_inc;
  logic       w_in_wait, w_good, w_fail;

  assign w_in_wait  = (r_state == S_PROBE_WAIT) || (r_state == S_ORIG_WAIT) ||
                      (r_state == S_POLL_WAIT);
  assign w_good     = rx_done && rx_ok;
  // A response arriving on the timeout cycle takes precedence over the timeout.
  assign w_fail     = (rx_done && !rx_ok) || (!rx_done && (r_timer == TO_LAST));
  assign w_miss_inc = (r_miss == 2'b11) ? 2'b11 : r_miss + 2'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_gap_tgt_nxt = r_gap_tgt;
    w_timer_clr   = 1'b0;
    w_link_nxt    = r_link;
    w_miss_nxt    = r_miss;
    w_rpt_nxt     = 1'b0;
    w_launch_poll = 1'b0;
    case (r_state)
      S_BACKOFF: begin
        if (r_timer == BO_LAST) begin
          w_state_nxt = S_PROBE_WAIT;
          w_timer_clr = 1'b1;
        end
      end
      S_PROBE_WAIT: begin
        if (w_good) begin
          w_state_nxt   = S_GAP;
          w_gap_tgt_nxt = S_ORIG_WAIT;
          w_timer_clr   = 1'b1;
        end else if (w_fail) begin
          w_state_nxt = S_BACKOFF;
          w_timer_clr = 1'b1;
        end
      end
      S_ORIG_WAIT: begin
        if (w_good) begin
          w_state_nxt   = S_GAP;
          w_gap_tgt_nxt = S_POLL_IDLE;
          w_timer_clr   = 1'b1;
          w_link_nxt    = 1'b1;
          w_miss_nxt    = 2'd0;
        end else if (w_fail) begin
          w_state_nxt = S_BACKOFF;
          w_timer_clr = 1'b1;
          w_link_nxt  = 1'b0;
        end
      end
      S_POLL_IDLE: begin
        if (r_pending) begin
          w_state_nxt   = S_POLL_WAIT;
          w_timer_clr   = 1'b1;
          w_launch_poll = 1'b1;
        end
      end
      S_POLL_WAIT: begin
        if (w_good) begin
          w_state_nxt   = S_GAP;
          w_gap_tgt_nxt = rx_origin_bit ? S_ORIG_WAIT : S_POLL_IDLE;
          w_timer_clr   = 1'b1;
          w_rpt_nxt     = 1'b1;
          w_miss_nxt    = 2'd0;
        end else if (w_fail) begin
          w_timer_clr = 1'b1;
          if (int'(w_miss_inc) == MAX_MISS) begin
            w_state_nxt = S_BACKOFF;
            w_link_nxt  = 1'b0;
            w_miss_nxt  = 2'd0;
          end else begin
            w_state_nxt   = S_GAP;
            w_gap_tgt_nxt = S_POLL_IDLE;
            w_miss_nxt    = w_miss_inc;
          end
        end
      end
      S_GAP: begin
        if (r_timer == GAP_LAST) begin
          w_state_nxt = r_gap_tgt;
          w_timer_clr = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_BACKOFF;
        w_timer_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_BACKOFF;
      r_gap_tgt <= S_POLL_IDLE;
      r_timer   <= '0;
      r_cmd     <= 3'd0;
      r_rumble  <= 1'b0;
      r_link    <= 1'b0;
      r_rpt     <= 1'b0;
      r_miss    <= 2'd0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_tgt <= w_gap_tgt_nxt;
      r_link    <= w_link_nxt;
      r_rpt     <= w_rpt_nxt;
      r_miss    <= w_miss_nxt;
      if (w_timer_clr)
        r_timer <= '0;
      else if (r_timer != '1)
        r_timer <= r_timer + 1'b1;
      if (w_state_nxt != r_state) begin
        case (w_state_nxt)
          S_PROBE_WAIT: r_cmd <= 3'd0;
          S_ORIG_WAIT:  r_cmd <= 3'd1;
          S_POLL_WAIT:  r_cmd <= 3'd2;
          default:      r_cmd <= r_cmd;
        endcase
      end
      if (w_launch_poll)
        r_rumble <= rumble_req;
      // A request arriving on the launch cycle belongs to the next poll.
      if (w_launch_poll)
        r_pending <= poll_req;
      else if (poll_req)
        r_pending <= 1'b1;
    end
  end

  assign gen_go    = w_in_wait;
  assign gen_hold  = !w_in_wait;
  assign cmd_type  = r_cmd;
  assign rumble    = r_rumble;
  assign link_up   = r_link;
  assign rpt_valid = r_rpt;
  assign miss_cnt  = r_miss;

endmodule

// File: tb/tb_gc_poll_scheduler.sv
// tb/tb_gc_poll_scheduler.sv - scoreboard bench for gc_poll_scheduler
// Expected launch commands are queued by each scenario and checked by a launch monitor.
module tb_gc_poll_scheduler;

  localparam int T  = 40;
  localparam int G  = 6;
  localparam int MM = 3;
  localparam int B  = 50;
  localparam int CW = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       poll_req = 1'b0, rumble_req = 1'b0;
  logic       rx_done = 1'b0, rx_ok = 1'b0, rx_origin_bit = 1'b0;
  logic       gen_hold, gen_go, rumble, link_up, rpt_valid;
  logic [2:0] cmd_type;
  logic [1:0] miss_cnt;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, launch_cnt = 0, last_launch_cyc = 0;
  logic prev_go = 1'b0;
  logic [2:0] exp_cmd[$];

  gc_poll_scheduler #(.TIMEOUT_CYC(T), .GAP_CYC(G), .MAX_MISS(MM),
                      .BACKOFF_CYC(B), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .poll_req(poll_req), .rumble_req(rumble_req),
    .rx_done(rx_done), .rx_ok(rx_ok), .rx_origin_bit(rx_origin_bit),
    .gen_hold(gen_hold), .gen_go(gen_go), .cmd_type(cmd_type), .rumble(rumble),
    .link_up(link_up), .rpt_valid(rpt_valid), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Launch monitor: every rising gen_go pops one expected command.
  always @(negedge clk) begin
    logic [2:0] e;
    if (rst) begin
      prev_go = 1'b0;
    end else begin
      if (gen_go && !prev_go) begin
        launch_cnt++;
        last_launch_cyc = cyc;
        n_tests++;
        if (exp_cmd.size() == 0) begin
          n_fail++;
          $display("FAIL launch_unexpected: cmd_type=%0d, expected no launch", cmd_type);
        end else begin
          e = exp_cmd.pop_front();
          if (cmd_type !== e) begin
            n_fail++;
            $display("FAIL launch_cmd: cmd_type=%0d expected %0d", cmd_type, e);
          end
        end
      end
      prev_go = gen_go;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_launch(input int budget, output bit ok);
    int s = launch_cnt;
    int n = 0;
    while (launch_cnt == s && n < budget) begin
      step();
      n++;
    end
    ok = (launch_cnt != s);
  endtask

  task automatic send_rx(input logic ok, input logic obit);
    rx_done = 1'b1; rx_ok = ok; rx_origin_bit = obit;
    step();
    rx_done = 1'b0; rx_ok = 1'b0; rx_origin_bit = 1'b0;
  endtask

  task automatic pulse_poll();
    poll_req = 1'b1;
    step();
    poll_req = 1'b0;
  endtask

  task automatic bring_up(output bit ok);
    send_rx(1'b1, 1'b0);
    exp_cmd.push_back(3'd1);
    wait_launch(G + 5, ok);
    send_rx(1'b1, 1'b0);
  endtask

  int c0;

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if ({gen_hold, gen_go, cmd_type, rumble, link_up, rpt_valid, miss_cnt} !== 10'b1_0_000_0_0_0_00) begin
      n_fail++;
      $display("FAIL reset_outputs: hold=%0b go=%0b cmd=%0d rum=%0b link=%0b rpt=%0b miss=%0d expected 1 0 0 0 0 0 0",
               gen_hold, gen_go, cmd_type, rumble, link_up, rpt_valid, miss_cnt);
    end
    c0 = cyc;
    rst = 1'b0;
  endtask

  task automatic test_backoff_probe();
    bit ok;
    int prev;
    exp_cmd.push_back(3'd0);
    wait_launch(B + 5, ok);
    n_tests++;
    if (!ok || last_launch_cyc - c0 != B) begin
      n_fail++;
      $display("FAIL first_probe_time: launched=%0b delay=%0d expected delay %0d", ok, last_launch_cyc - c0, B);
    end
    prev = last_launch_cyc;
    exp_cmd.push_back(3'd0);
    wait_launch(B + T + 5, ok);
    n_tests++;
    if (!ok || last_launch_cyc - prev != B + T) begin
      n_fail++;
      $display("FAIL probe_period: launched=%0b period=%0d expected %0d", ok, last_launch_cyc - prev, B + T);
    end
    n_tests++;
    if (link_up !== 1'b0) begin
      n_fail++;
      $display("FAIL probe_link_up: link_up=%0b expected 0", link_up);
    end
  endtask

  task automatic test_link_up();
    bit ok;
    int e;
    pulse_poll();
    send_rx(1'b1, 1'b0);
    e = cyc;
    exp_cmd.push_back(3'd1);
    wait_launch(G + 5, ok);
    n_tests++;
    if (!ok || last_launch_cyc - e != G || link_up !== 1'b0) begin
      n_fail++;
      $display("FAIL origin_launch: launched=%0b delay=%0d link=%0b expected delay %0d link 0",
               ok, last_launch_cyc - e, link_up, G);
    end
    send_rx(1'b1, 1'b0);
    e = cyc;
    n_tests++;
    if (link_up !== 1'b1 || miss_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL origin_link_up: link=%0b miss=%0d expected 1 0", link_up, miss_cnt);
    end
    exp_cmd.push_back(3'd2);
    wait_launch(G + 5, ok);
    n_tests++;
    if (!ok || last_launch_cyc - e != G + 1) begin
      n_fail++;
      $display("FAIL first_poll_time: launched=%0b delay=%0d expected %0d", ok, last_launch_cyc - e, G + 1);
    end
    send_rx(1'b1, 1'b0);
    n_tests++;
    if (rpt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rpt_valid_pulse: rpt_valid=%0b expected 1", rpt_valid);
    end
    step();
    n_tests++;
    if (rpt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rpt_valid_width: rpt_valid=%0b expected 0", rpt_valid);
    end
  endtask

  task automatic test_rumble();
    bit ok;
    rumble_req = 1'b1;
    pulse_poll();
    exp_cmd.push_back(3'd2);
    wait_launch(G + 5, ok);
    rumble_req = 1'b0;
    n_tests++;
    if (!ok || rumble !== 1'b1) begin
      n_fail++;
      $display("FAIL rumble_latch: launched=%0b rumble=%0b expected 1", ok, rumble);
    end
    repeat (4) step();
    n_tests++;
    if (rumble !== 1'b1 || gen_go !== 1'b1) begin
      n_fail++;
      $display("FAIL rumble_frozen: rumble=%0b go=%0b expected 1 1", rumble, gen_go);
    end
    send_rx(1'b1, 1'b0);
    n_tests++;
    if (rpt_valid !== 1'b1 || gen_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL rumble_reply: rpt_valid=%0b hold=%0b expected 1 1", rpt_valid, gen_hold);
    end
  endtask

  task automatic test_reorigin();
    bit ok;
    pulse_poll();
    exp_cmd.push_back(3'd2);
    wait_launch(G + 5, ok);
    send_rx(1'b1, 1'b1);
    exp_cmd.push_back(3'd1);
    wait_launch(G + 5, ok);
    n_tests++;
    if (!ok || link_up !== 1'b1) begin
      n_fail++;
      $display("FAIL reorigin: launched=%0b link=%0b expected 1 1", ok, link_up);
    end
    send_rx(1'b1, 1'b0);
    pulse_poll();
    exp_cmd.push_back(3'd2);
    wait_launch(G + 5, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reorigin_resume: launched=%0b expected 1", ok);
    end
    send_rx(1'b1, 1'b0);
  endtask

  task automatic poll_timeout(input logic [1:0] exp_miss, input string nm);
    bit ok;
    int n = 0;
    pulse_poll();
    exp_cmd.push_back(3'd2);
    wait_launch(G + 5, ok);
    while (miss_cnt == exp_miss - 2'd1 && n < T + 5) begin
      step();
      n++;
    end
    n_tests++;
    if (!ok || miss_cnt !== exp_miss || link_up !== 1'b1 || cyc - last_launch_cyc != T) begin
      n_fail++;
      $display("FAIL %s: miss=%0d link=%0b after=%0d expected miss %0d link 1 after %0d",
               nm, miss_cnt, link_up, cyc - last_launch_cyc, exp_miss, T);
    end
  endtask

  task automatic test_misses();
    bit ok;
    int n = 0;
    int f;
    poll_timeout(2'd1, "miss_one");
    poll_timeout(2'd2, "miss_two");
    pulse_poll();
    exp_cmd.push_back(3'd2);
    wait_launch(G + 5, ok);
    send_rx(1'b1, 1'b0);
    n_tests++;
    if (miss_cnt !== 2'd0 || rpt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_clear: miss=%0d rpt=%0b expected 0 1", miss_cnt, rpt_valid);
    end
    poll_timeout(2'd1, "miss_one_again");
    poll_timeout(2'd2, "miss_two_again");
    pulse_poll();
    exp_cmd.push_back(3'd2);
    wait_launch(G + 5, ok);
    while (link_up == 1'b1 && n < T + 5) begin
      step();
      n++;
    end
    f = cyc;
    n_tests++;
    if (link_up !== 1'b0 || miss_cnt !== 2'd0 || gen_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_fallback: link=%0b miss=%0d hold=%0b expected 0 0 1", link_up, miss_cnt, gen_hold);
    end
    exp_cmd.push_back(3'd0);
    wait_launch(B + 5, ok);
    n_tests++;
    if (!ok || last_launch_cyc - f != B) begin
      n_fail++;
      $display("FAIL fallback_probe: launched=%0b delay=%0d expected %0d", ok, last_launch_cyc - f, B);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bring_up(ok);
    pulse_poll();
    exp_cmd.push_back(3'd2);
    wait_launch(G + 5, ok);
    repeat (3) begin
      pulse_poll();
      step();
    end
    send_rx(1'b1, 1'b0);
    exp_cmd.push_back(3'd2);
    wait_launch(G + 5, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL merged_poll: launched=%0b expected 1", ok);
    end
    send_rx(1'b1, 1'b0);
    wait_launch(G + 20, ok);
    n_tests++;
    if (ok) begin
      n_fail++;
      $display("FAIL extra_poll: launched=%0b expected 0", ok);
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    rumble_req = 1'b1;
    pulse_poll();
    exp_cmd.push_back(3'd2);
    wait_launch(G + 5, ok);
    rumble_req = 1'b0;
    poll_req = 1'b1;
    rst = 1'b1;
    step();
    poll_req = 1'b0;
    n_tests++;
    if ({gen_hold, gen_go, cmd_type, rumble, link_up, rpt_valid, miss_cnt} !== 10'b1_0_000_0_0_0_00) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: hold=%0b go=%0b cmd=%0d rum=%0b link=%0b rpt=%0b miss=%0d expected 1 0 0 0 0 0 0",
               gen_hold, gen_go, cmd_type, rumble, link_up, rpt_valid, miss_cnt);
    end
    c0 = cyc;
    rst = 1'b0;
    send_rx(1'b1, 1'b0);
    exp_cmd.push_back(3'd0);
    wait_launch(B + 5, ok);
    n_tests++;
    if (!ok || last_launch_cyc - c0 != B) begin
      n_fail++;
      $display("FAIL rst_probe_time: launched=%0b delay=%0d expected %0d", ok, last_launch_cyc - c0, B);
    end
    bring_up(ok);
    n_tests++;
    if (!ok || link_up !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_relink: launched=%0b link=%0b expected 1 1", ok, link_up);
    end
    wait_launch(G + 10, ok);
    n_tests++;
    if (ok) begin
      n_fail++;
      $display("FAIL rst_pending_cleared: launched=%0b expected 0", ok);
    end
  endtask

  initial begin
    test_reset();
    test_backoff_probe();
    test_link_up();
    test_rumble();
    test_reorigin();
    test_misses();
    test_back_to_back();
    test_rst_mid();
    n_tests++;
    if (exp_cmd.size() != 0) begin
      n_fail++;
      $display("FAIL launches_outstanding: %0d left expected 0", exp_cmd.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
